// File: rtl/valid_data_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/data channel among NUM_REQ
// producers; an owner may stream up to MAX_BURST back-to-back beats before yielding.
module valid_data_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]         req_grant_o,
  output logic                       out_valid_o,
  output logic [DATA_W-1:0]          out_data_o,
  output logic [$clog2(NUM_REQ)-1:0] out_owner_o,
  output logic                       busy_o
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

  typedef enum logic {IDLE, BURST} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [OW-1:0]       last_q, last_d;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [OW-1:0]       out_owner_q;

  logic                keep;
  logic                found;
  logic [OW-1:0]       win, sel;
  logic [NUM_REQ-1:0]  grant;

  // Scan starts just past the last winner, so the previous owner is checked last.
  always_comb begin : arb
    int            idx;
    logic [OW-1:0] ci;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    ci    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      ci = OW'(idx);
      if (!found && req_valid_i[ci]) begin
        found = 1'b1;
        win   = ci;
      end
    end
  end

  assign keep = (state_q == BURST) && req_valid_i[last_q] && (count_q < MAXC);

  always_comb begin
    grant   = '0;
    sel     = last_q;
    state_d = state_q;
    count_d = count_q;
    last_d  = last_q;
    if (keep) begin
      grant[last_q] = 1'b1;
      count_d       = count_q + CW'(1);
    end else if (found) begin
      grant[win] = 1'b1;
      sel        = win;
      last_d     = win;
      count_d    = CW'(1);
      state_d    = (MAX_BURST > 1) ? BURST : IDLE;
    end else begin
      state_d = IDLE;
      count_d = '0;
    end
    if (rst_i) grant = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      count_q     <= '0;
      last_q      <= OW'(NUM_REQ - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_owner_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      last_q      <= last_d;
      out_valid_q <= |grant;
      if (|grant) begin
        out_data_q  <= req_data_i[sel*DATA_W +: DATA_W];
        out_owner_q <= sel;
      end
    end
  end

  assign req_grant_o = grant;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_owner_o = out_owner_q;
  assign busy_o      = (state_q == BURST);
endmodule

// File: tb/tb_valid_data_rr_arbiter.sv
// Table-driven bench: per-cycle grant/busy vectors, registered outputs checked
// one cycle later through a scoreboard queue; second instance covers MAX_BURST=1.
module tb_valid_data_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [3:0] req_data  = '0;
  logic [3:0] req_grant;
  logic       out_valid;
  logic       out_data;
  logic [1:0] out_owner;
  logic       busy;

  logic       rst2 = 1'b1;
  logic [2:0] req_valid2 = '0;
  logic [2:0] req_data2  = '0;
  logic [2:0] req_grant2;
  logic       out_valid2;
  logic       out_data2;
  logic [1:0] out_owner2;
  logic       busy2;

  always #5 clk = ~clk;

  valid_data_rr_arbiter #(.NUM_REQ(4), .DATA_W(1), .MAX_BURST(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_grant_o(req_grant), .out_valid_o(out_valid), .out_data_o(out_data),
    .out_owner_o(out_owner), .busy_o(busy));

  valid_data_rr_arbiter #(.NUM_REQ(3), .DATA_W(1), .MAX_BURST(1)) dut2 (
    .clk_i(clk), .rst_i(rst2), .req_valid_i(req_valid2), .req_data_i(req_data2),
    .req_grant_o(req_grant2), .out_valid_o(out_valid2), .out_data_o(out_data2),
    .out_owner_o(out_owner2), .busy_o(busy2));

  typedef struct { logic r; logic [3:0] v; logic [3:0] g; logic b; } vec_t;
  typedef struct { logic v; logic d; logic [1:0] o; } exp_t;

  vec_t tv[$];
  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic       exp_d = 1'b0;
  logic [1:0] exp_o = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic [3:0] v, input logic [3:0] g, input logic b);
    tv.push_back('{r, v, g, b});
  endfunction

  function automatic logic [1:0] oh_idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic run1(input vec_t t, input int i);
    exp_t e, got;
    rst       = t.r;
    req_valid = t.v;
    req_data  = 4'($urandom);
    #1;
    chk($sformatf("grant[%0d]", i), 32'(req_grant), 32'(t.g));
    chk($sformatf("busy[%0d]", i), 32'(busy), 32'(t.b));
    if (t.r) begin
      chk($sformatf("rst_valid[%0d]", i), 32'(out_valid), 0);
      chk($sformatf("rst_data[%0d]", i), 32'(out_data), 0);
      chk($sformatf("rst_owner[%0d]", i), 32'(out_owner), 0);
      exp_d = 1'b0;
      exp_o = '0;
      e = '{1'b0, 1'b0, 2'd0};
    end else if (|t.g) begin
      exp_o = oh_idx(t.g);
      exp_d = req_data[exp_o];
      e = '{1'b1, exp_d, exp_o};
    end else begin
      e = '{1'b0, exp_d, exp_o};
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    chk($sformatf("out_valid[%0d]", i), 32'(out_valid), 32'(got.v));
    chk($sformatf("out_data[%0d]", i), 32'(out_data), 32'(got.d));
    chk($sformatf("out_owner[%0d]", i), 32'(out_owner), 32'(got.o));
  endtask

  initial begin
    // 1: sole requester re-wins after the burst limit with no gap
    add(1, 4'b0000, 4'b0000, 0);
    add(0, 4'b0001, 4'b0001, 0);
    for (int k = 0; k < 3; k++) add(0, 4'b0001, 4'b0001, 1);
    add(0, 4'b0001, 4'b0001, 1);
    add(0, 4'b0001, 4'b0001, 1);
    add(0, 4'b0000, 4'b0000, 1);
    add(0, 4'b0000, 4'b0000, 0);
    // 2: all requesting, bursts of 4 rotate
    add(1, 4'b0000, 4'b0000, 0);
    add(0, 4'b1111, 4'b0001, 0);
    for (int k = 0; k < 3; k++) add(0, 4'b1111, 4'b0001, 1);
    for (int k = 0; k < 4; k++) add(0, 4'b1111, 4'b0010, 1);
    for (int k = 0; k < 4; k++) add(0, 4'b1111, 4'b0100, 1);
    add(0, 4'b1111, 4'b1000, 1);
    add(0, 4'b0000, 4'b0000, 1);
    add(0, 4'b0000, 4'b0000, 0);
    // 3: req0 drops after two beats, req2 takes over, then back to req0
    add(1, 4'b0000, 4'b0000, 0);
    add(0, 4'b0101, 4'b0001, 0);
    add(0, 4'b0101, 4'b0001, 1);
    add(0, 4'b0100, 4'b0100, 1);
    for (int k = 0; k < 3; k++) add(0, 4'b0101, 4'b0100, 1);
    add(0, 4'b0101, 4'b0001, 1);
    add(0, 4'b0000, 4'b0000, 1);
    add(0, 4'b0000, 4'b0000, 0);
    // 4: single pulse on req3 from IDLE
    add(0, 4'b1000, 4'b1000, 0);
    add(0, 4'b0000, 4'b0000, 1);
    add(0, 4'b0000, 4'b0000, 0);
    // 5: reset during third beat of a req1 burst, req1 wins first afterwards
    add(1, 4'b0000, 4'b0000, 0);
    add(0, 4'b0010, 4'b0010, 0);
    add(0, 4'b0010, 4'b0010, 1);
    add(1, 4'b0010, 4'b0000, 0);
    add(0, 4'b0110, 4'b0010, 0);
    add(0, 4'b0110, 4'b0010, 1);
    add(0, 4'b0000, 4'b0000, 1);
    add(0, 4'b0000, 4'b0000, 0);

    foreach (tv[i]) run1(tv[i], i);

    // 6: NUM_REQ=3, MAX_BURST=1, strict alternation and never busy
    rst2       = 1'b1;
    req_valid2 = 3'b111;
    #1;
    chk("t6_rst_grant", 32'(req_grant2), 0);
    chk("t6_rst_valid", 32'(out_valid2), 0);
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp_t e, got;
      logic [2:0] g;
      g = 3'(1 << (k % 3));
      req_data2 = 3'($urandom);
      #1;
      chk($sformatf("t6_grant[%0d]", k), 32'(req_grant2), 32'(g));
      chk($sformatf("t6_busy[%0d]", k), 32'(busy2), 0);
      e = '{1'b1, req_data2[k % 3], 2'(k % 3)};
      sbq.push_back(e);
      @(posedge clk);
      #1;
      got = sbq.pop_front();
      chk($sformatf("t6_valid[%0d]", k), 32'(out_valid2), 32'(got.v));
      chk($sformatf("t6_data[%0d]", k), 32'(out_data2), 32'(got.d));
      chk($sformatf("t6_owner[%0d]", k), 32'(out_owner2), 32'(got.o));
    end
    chk("t6_busy_end", 32'(busy2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
